// File: rtl/robs_control.sv
// ----------------------------------------------------------------------------
// robs_control
// Moore-FSM sequencer for the signed Robertson's multiplier datapath
// (robs_datapath). It drives the datapath's 15-bit control vector and
// consumes its status flags. It also gives the top level a
// start/busy/done handshake.
//
// Optional build macro: ROBS_CTRL_PERF_EN
//   When defined, this block adds a cycle counter output and a sticky error
//   flag. The flag is set when the iteration count and the datapath
//   counter flag zq disagree in CHECK.
//
// Ports:
//   clk     in   1   clock, rising edge
//   reset   in   1   asynchronous, active-low reset
//   start   in   1   multiply request, sampled only in IDLE
//   zr      in   1   datapath: R is even
//   zq      in   1   datapath: down-counter divisible by 8
//   c       out  15  datapath control vector
//   busy    out  1   high in every state except IDLE
//   done    out  1   one-cycle pulse, product valid on the datapath
//   cycles  out  16  (ROBS_CTRL_PERF_EN) cycles since INIT
//   err     out  1   (ROBS_CTRL_PERF_EN) sticky zq/iteration mismatch
//
// c bit map:
//   0 LDY, 1 LDCNT, 2 CLRA, 3 LDX, 5:4 SELRH (0 A, 1 shift-hi, 2 ALU)
//   6 SELRL (0 X, 1 shift-lo), 7 SELX (0 multiplier, 1 R low)
//   8 LDRH, 9 LDRL, 10 ADD (1 add, 0 sub), 11 SHIFT, 12 LDSR, 13 DEC, 14 LDA
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// INIT   | load Y and X, clear A, load the datapath counter
// LOADR  | R <= {A, X}
// TEST   | inspect the R LSB (zr)
// ADD    | ALU add Y, or subtract Y on the sign-bit step
// ADD_WB | write the registered ALU result into R high half
// SH_LD  | load the shift register from R
// SH_EX  | arithmetic right shift by one
// SH_WB  | write the shifted R back, decrement the counter, it++
// CHECK  | loop back to TEST or leave via FIN
// FIN    | A and X take the product halves
// DONE   | done pulse
// ----------------------------------------------------------------------------
module robs_control #(
    parameter int WIDTH = 8,
    parameter int ITW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        zr,
    input  logic        zq,
    output logic [14:0] c,
    output logic        busy,
    output logic        done
`ifdef ROBS_CTRL_PERF_EN
    ,
    output logic [15:0] cycles,
    output logic [0:0]  err
`endif
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_INIT   = 4'd1;
    localparam logic [3:0] S_LOADR  = 4'd2;
    localparam logic [3:0] S_TEST   = 4'd3;
    localparam logic [3:0] S_ADD    = 4'd4;
    localparam logic [3:0] S_ADD_WB = 4'd5;
    localparam logic [3:0] S_SH_LD  = 4'd6;
    localparam logic [3:0] S_SH_EX  = 4'd7;
    localparam logic [3:0] S_SH_WB  = 4'd8;
    localparam logic [3:0] S_CHECK  = 4'd9;
    localparam logic [3:0] S_FIN    = 4'd10;
    localparam logic [3:0] S_DONE   = 4'd11;

    localparam int C_LDY   = 0;
    localparam int C_LDCNT = 1;
    localparam int C_CLRA  = 2;
    localparam int C_LDX   = 3;
    localparam int C_SELRL = 6;
    localparam int C_SELX  = 7;
    localparam int C_LDRH  = 8;
    localparam int C_LDRL  = 9;
    localparam int C_ADD   = 10;
    localparam int C_SHIFT = 11;
    localparam int C_LDSR  = 12;
    localparam int C_DEC   = 13;
    localparam int C_LDA   = 14;

    // The counter needs one bit more than ITW so that it can hold WIDTH itself.
    localparam int           LAST_I  = WIDTH - 1;
    localparam logic [ITW:0] IT_END  = WIDTH[ITW:0];
    localparam logic [ITW:0] IT_LAST = LAST_I[ITW:0];
    localparam logic [ITW:0] IT_ONE  = {{ITW{1'b0}}, 1'b1};

    logic [3:0]   state;
    logic [3:0]   state_nx;
    logic [ITW:0] it;
    logic         it_end;
    logic         sub_step;

    assign it_end   = (it == IT_END);
    assign sub_step = (it == IT_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_INIT;
            S_INIT:   state_nx = S_LOADR;
            S_LOADR:  state_nx = S_TEST;
            S_TEST:   state_nx = zr ? S_SH_LD : S_ADD;
            S_ADD:    state_nx = S_ADD_WB;
            S_ADD_WB: state_nx = S_SH_LD;
            S_SH_LD:  state_nx = S_SH_EX;
            S_SH_EX:  state_nx = S_SH_WB;
            S_SH_WB:  state_nx = S_CHECK;
            // Any disagreement between zq and the iteration count still
            // leaves through FIN so that the handshake always completes.
            S_CHECK:  state_nx = (zq || it_end) ? S_FIN : S_TEST;
            S_FIN:    state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            it <= '0;
        end else if (state == S_INIT) begin
            it <= '0;
        end else if (state == S_SH_WB && !it_end) begin
            it <= it + IT_ONE;
        end
    end

    // Only the sign-bit step (it == WIDTH-1) subtracts. ADD_WB repeats the
    // ADD-state polarity because the datapath adder is registered.
    always_comb begin
        c = '0;
        case (state)
            S_INIT: begin
                c[C_LDY]   = 1'b1;
                c[C_LDCNT] = 1'b1;
                c[C_CLRA]  = 1'b1;
                c[C_LDX]   = 1'b1;
            end
            S_LOADR: begin
                c[C_LDRH] = 1'b1;
                c[C_LDRL] = 1'b1;
            end
            S_ADD: begin
                c[C_ADD] = ~sub_step;
            end
            S_ADD_WB: begin
                c[5:4]    = 2'd2;
                c[C_LDRH] = 1'b1;
                c[C_ADD]  = ~sub_step;
            end
            S_SH_LD: c[C_LDSR]  = 1'b1;
            S_SH_EX: c[C_SHIFT] = 1'b1;
            S_SH_WB: begin
                c[5:4]     = 2'd1;
                c[C_SELRL] = 1'b1;
                c[C_LDRH]  = 1'b1;
                c[C_LDRL]  = 1'b1;
                c[C_DEC]   = 1'b1;
            end
            S_FIN: begin
                c[C_LDA]  = 1'b1;
                c[C_LDX]  = 1'b1;
                c[C_SELX] = 1'b1;
            end
            default: c = '0;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

`ifdef ROBS_CTRL_PERF_EN
    logic mismatch;
    assign mismatch = zq ^ it_end;

    // Counters clear on the IDLE->INIT edge so INIT reads 0. DONE does not
    // count, so the held value is the number of states after INIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
            err    <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (start) begin
                    cycles <= '0;
                    err    <= '0;
                end
            end else if (state != S_DONE) begin
                cycles <= cycles + 16'd1;
            end
            if (state == S_CHECK && mismatch) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_robs_control.sv
module tb_robs_control;

    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        zr;
    logic        zq;
    logic [14:0] c;
    logic        busy;
    logic        done;
`ifdef ROBS_CTRL_PERF_EN
    logic [15:0] cycles;
    logic [0:0]  err;
`endif

    always #5 clk = ~clk;

    robs_control #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .zr    (zr),
        .zq    (zq),
        .c     (c),
        .busy  (busy),
        .done  (done)
`ifdef ROBS_CTRL_PERF_EN
        ,
        .cycles(cycles),
        .err   (err)
`endif
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operands and a minimal datapath stand-in for the status flags.
    logic [7:0] mcand  = 8'd0;
    logic [7:0] mplier = 8'd0;
    logic       force_zq = 1'b0;
    logic [3:0] decs = 4'd0;

    assign zr = ~mplier[decs[2:0]];
    assign zq = force_zq | (decs == 4'd0) | (decs == 4'd8);

    always @(negedge clk) begin
        if (c[1])       decs <= 4'd0;
        else if (c[13]) decs <= decs + 4'd1;
    end

    // Expected-output model: one queue entry per non-IDLE state, built from
    // the operation's multiplier bits when start is accepted.
    typedef struct packed {
        logic        err;
        logic [15:0] cyc;
        logic        busy;
        logic        done;
        logic [14:0] c;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;

    task automatic push(input logic [14:0] cv, input logic dn, input logic er);
        exp_t e;
        e.c    = cv;
        e.done = dn;
        e.busy = 1'b1;
        e.cyc  = 16'(q.size());
        e.err  = er;
        q.push_back(e);
    endtask

    task automatic build(input int n_iter, input logic [7:0] m, input logic forced);
        logic [14:0] addb;
        q.delete();
        push(15'h000F, 1'b0, 1'b0);              // INIT
        push(15'h0300, 1'b0, 1'b0);              // LOADR
        for (int i = 0; i < n_iter; i++) begin
            push(15'h0000, 1'b0, 1'b0);          // TEST
            if (m[i]) begin
                addb = (i != WIDTH - 1) ? 15'h0400 : 15'h0000;
                push(addb, 1'b0, 1'b0);          // ADD
                push(15'h0120 | addb, 1'b0, 1'b0); // ADD_WB
            end
            push(15'h1000, 1'b0, 1'b0);          // SH_LD
            push(15'h0800, 1'b0, 1'b0);          // SH_EX
            push(15'h2350, 1'b0, 1'b0);          // SH_WB
            push(15'h0000, 1'b0, 1'b0);          // CHECK
        end
        push(15'h4088, 1'b0, forced);            // FIN
        push(15'h0000, 1'b1, forced);            // DONE
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                q.delete();
                cur = '0;
            end else if (!cur.busy) begin
                if (start) begin
                    build(force_zq ? 1 : WIDTH, mplier, force_zq);
                    cur = q.pop_front();
                end
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur.busy = 1'b0;
                cur.done = 1'b0;
                cur.c    = '0;
            end
        end
    end

    // Per-cycle compare plus a product reconstruction from the control stream.
    logic signed [15:0] prod = '0;
    logic signed [15:0] ysx;
    int t = 0, adds = 0, subs = 0, sub_it = -1;
    int done_cnt = 0, done_t = 0, done_adds = 0, done_subs = 0, done_sub_it = 0;
    logic [15:0] done_prod = '0;
    logic [15:0] done_cyc = '0;
    logic        done_err = 1'b0;

    assign ysx = {{8{mcand[7]}}, mcand};

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("outputs", 32'({busy, done, c}), 32'({cur.busy, cur.done, cur.c}));
`ifdef ROBS_CTRL_PERF_EN
                check("cycles", 32'(cycles), 32'(cur.cyc));
                check("err", 32'(err), 32'(cur.err));
`endif
            end
            if (c[1]) begin
                prod = '0; t = 1; adds = 0; subs = 0; sub_it = -1;
            end else begin
                t++;
            end
            if (c[8] && c[5:4] == 2'b10) begin
                if (c[10]) begin
                    prod = prod + (ysx <<< decs);
                    adds++;
                end else begin
                    prod = prod - (ysx <<< decs);
                    subs++;
                    sub_it = int'(decs);
                end
            end
            if (done) begin
                done_t = t; done_prod = prod; done_adds = adds;
                done_subs = subs; done_sub_it = sub_it;
`ifdef ROBS_CTRL_PERF_EN
                done_cyc = cycles; done_err = err;
`endif
                done_cnt++;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] mc, input logic [7:0] mp);
        mcand  = mc;
        mplier = mp;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        base = done_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base) return;
        end
        n_checks++;
        n_errs++;
        $display("FAIL %s: done timeout, got none expected one within 200 cycles", name);
    endtask

    task automatic check_op(input string name, input logic [15:0] p, input int tt,
                            input int na, input int ns);
        check({name, "_prod"}, 32'(done_prod), 32'(p));
        check({name, "_latency"}, 32'(done_t), 32'(tt));
        check({name, "_adds"}, 32'(done_adds), 32'(na));
        check({name, "_subs"}, 32'(done_subs), 32'(ns));
    endtask

    initial begin
        bit seen;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", 32'({busy, done, c}), 32'h0);
`ifdef ROBS_CTRL_PERF_EN
        check("reset_cycles", 32'(cycles), 32'h0);
`endif
        reset = 1'b1;
        @(negedge clk);

        pulse_start(8'd5, 8'd3);
        wait_done("mul_5x3");
        check_op("mul_5x3", 16'h000F, 48, 2, 0);
`ifdef ROBS_CTRL_PERF_EN
        check("mul_5x3_cycles", 32'(done_cyc), 32'd47);
        check("mul_5x3_err", 32'(done_err), 32'd0);
`endif

        // Abort in SH_EX with an asynchronous reset.
        pulse_start(8'd5, 8'd3);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (c[11]) seen = 1'b1;
        end
        check("reach_sh_ex", 32'(seen), 32'd1);
        #1 reset = 1'b0;
        #1 check("async_reset", 32'({busy, done, c}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        pulse_start(8'd7, 8'd6);
        wait_done("mul_7x6");
        check_op("mul_7x6", 16'h002A, 48, 2, 0);

        pulse_start(8'd5, 8'hFD);
        wait_done("mul_5xm3");
        check_op("mul_5xm3", 16'hFFF1, 58, 6, 1);
        check("mul_5xm3_sub_it", 32'(done_sub_it), 32'd7);

        pulse_start(8'h80, 8'h80);
        wait_done("mul_m128");
        check_op("mul_m128", 16'h4000, 46, 0, 1);
        check("mul_m128_sub_it", 32'(done_sub_it), 32'd7);

        // Zero multiplier, start pulsed while busy, start held through DONE.
        pulse_start(8'h7F, 8'h00);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        wait_done("mul_zero");
        check_op("mul_zero", 16'h0000, 44, 0, 0);
`ifdef ROBS_CTRL_PERF_EN
        check("mul_zero_cycles", 32'(done_cyc), 32'd43);
`endif
        @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("restart_init", 32'(c), 32'h000F);
        start = 1'b0;
        wait_done("restart");
        check_op("restart", 16'h0000, 44, 0, 0);

        // zq forced high: first CHECK disagrees with the iteration count.
        force_zq = 1'b1;
        pulse_start(8'd5, 8'd3);
        wait_done("forced_zq");
        force_zq = 1'b0;
        check_op("forced_zq", 16'h0005, 11, 1, 0);
`ifdef ROBS_CTRL_PERF_EN
        check("forced_zq_err", 32'(done_err), 32'd1);
        check("forced_zq_cycles", 32'(done_cyc), 32'd10);
`endif

        pulse_start(8'd5, 8'd3);
        wait_done("after_forced");
        check_op("after_forced", 16'h000F, 48, 2, 0);
`ifdef ROBS_CTRL_PERF_EN
        check("after_forced_err", 32'(done_err), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
